// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the CPU multicycle
// controller and the DMA/loader requester.
//
// Each requester runs a req/ack handshake. In IDLE the arbiter picks one
// requester, then latches that requester's address, write data and direction
// into the memory port. It holds the read or write strobe for MEM_LAT cycles,
// then pulses the winner's ack for one cycle. Read data is captured into rdata
// on the last strobe cycle. rdata keeps that value until the next completed
// read.
//
// Arbitration:
//   default                    round-robin; the first tie after reset goes to the CPU
//   ARB_CPU_PRIORITY_EN macro  fixed priority; the CPU wins every tie
//
// Ports:
//   Clk, Reset                        clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata  (in)       CPU request, held until cpu_ack
//   cpu_gnt, cpu_ack       (out)      CPU owns port / one-cycle completion
//   dma_req/we/addr/wdata  (in)       DMA request, held until dma_ack
//   dma_gnt, dma_ack       (out)      DMA owns port / one-cycle completion
//   rdata                  (out)      data of the last completed read
//   mem_addr, mem_wdata    (out)      memory address / write data
//   mem_rd, mem_wr         (out)      memory read / write strobes
//   mem_rdata              (in)       memory read data, valid on last strobe cycle
//
// Parameters: ADDR_W, DATA_W, MEM_LAT (strobe cycles, 1..15).
// All outputs are registered.

module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic SEL_CPU = 1'b0;
  localparam logic SEL_DMA = 1'b1;

  // The latency counter is 4 bits wide, so MEM_LAT must be in 1..15.
  if (MEM_LAT == 0 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_gnt_q, last_gnt_d;

  logic               cpu_gnt_d, dma_gnt_d;
  logic               cpu_ack_d, dma_ack_d;
  logic               mem_rd_d, mem_wr_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_d;
  logic [DATA_W-1:0]  rdata_d;

  logic               pick_dma;
  logic               sel_we;

  // Arbitration: decide who would win if the arbiter accepted a request now.
  always_comb begin
`ifdef ARB_CPU_PRIORITY_EN
    pick_dma = ~cpu_req;
`else
    // A lone DMA request wins. On a tie, the grant goes to whoever did not win last time.
    pick_dma = dma_req & (~cpu_req | (last_gnt_q == SEL_CPU));
`endif
  end

  assign sel_we = pick_dma ? dma_we : cpu_we;

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_gnt_q <= SEL_DMA;
      cpu_gnt    <= 1'b0;
      dma_gnt    <= 1'b0;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      cpu_gnt    <= cpu_gnt_d;
      dma_gnt    <= dma_gnt_d;
      cpu_ack    <= cpu_ack_d;
      dma_ack    <= dma_ack_d;
      mem_rd     <= mem_rd_d;
      mem_wr     <= mem_wr_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      rdata      <= rdata_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_gnt_d  = last_gnt_q;
    cpu_gnt_d   = cpu_gnt;
    dma_gnt_d   = dma_gnt;
    cpu_ack_d   = cpu_ack;
    dma_ack_d   = dma_ack;
    mem_rd_d    = mem_rd;
    mem_wr_d    = mem_wr;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    rdata_d     = rdata;

    unique case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          mem_addr_d  = pick_dma ? dma_addr  : cpu_addr;
          mem_wdata_d = pick_dma ? dma_wdata : cpu_wdata;
          mem_rd_d    = ~sel_we;
          mem_wr_d    = sel_we;
          cpu_gnt_d   = ~pick_dma;
          dma_gnt_d   = pick_dma;
          cnt_d       = CNT_W'(MEM_LAT - 1);
          last_gnt_d  = pick_dma ? SEL_DMA : SEL_CPU;
          state_d     = BUSY;
        end
      end

      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Last strobe cycle: capture read data and raise the owner's ack.
          if (mem_rd) begin
            rdata_d = mem_rdata;
          end
          mem_rd_d  = 1'b0;
          mem_wr_d  = 1'b0;
          cpu_ack_d = cpu_gnt;
          dma_ack_d = dma_gnt;
          state_d   = RESP;
        end
      end

      RESP: begin
        cpu_ack_d = 1'b0;
        dma_ack_d = 1'b0;
        cpu_gnt_d = 1'b0;
        dma_gnt_d = 1'b0;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a table of single transactions, hand-written
// corner sequences (reset in BUSY, held ties, MEM_LAT=1), and randomized
// traffic checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_gnt, cpu_ack, dma_gnt, dma_ack;
  logic [15:0] rdata, mem_addr, mem_wdata;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_rdata;

  // Second instance with MEM_LAT = 1.
  logic        c1_cpu_req, c1_cpu_we, c1_dma_req, c1_dma_we;
  logic [15:0] c1_cpu_addr, c1_cpu_wdata, c1_dma_addr, c1_dma_wdata;
  logic        c1_cpu_gnt, c1_cpu_ack, c1_dma_gnt, c1_dma_ack;
  logic [15:0] c1_rdata, c1_mem_addr, c1_mem_wdata;
  logic        c1_mem_rd, c1_mem_wr;
  logic [15:0] c1_mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(L)) dut (
    .Clk(clk), .Reset(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_ack(dma_ack),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut1 (
    .Clk(clk), .Reset(rst_n),
    .cpu_req(c1_cpu_req), .cpu_we(c1_cpu_we), .cpu_addr(c1_cpu_addr), .cpu_wdata(c1_cpu_wdata),
    .cpu_gnt(c1_cpu_gnt), .cpu_ack(c1_cpu_ack),
    .dma_req(c1_dma_req), .dma_we(c1_dma_we), .dma_addr(c1_dma_addr), .dma_wdata(c1_dma_wdata),
    .dma_gnt(c1_dma_gnt), .dma_ack(c1_dma_ack),
    .rdata(c1_rdata), .mem_addr(c1_mem_addr), .mem_wdata(c1_mem_wdata),
    .mem_rd(c1_mem_rd), .mem_wr(c1_mem_wr), .mem_rdata(c1_mem_rdata)
  );

  // Unwritten memory content: 0x0010 holds 0xBEEF, everything else addr^0xA5A5.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'hA5A5);
  endfunction

  // Memory macro: data is valid only on the last strobe cycle, garbage otherwise.
  logic [15:0] env_mem [logic [15:0]];
  int unsigned scnt = 0;

  always @(posedge clk) begin
    if (mem_wr) env_mem[mem_addr] = mem_wdata;
    if (mem_rd || mem_wr) scnt <= scnt + 1;
    else                  scnt <= 0;
  end

  always @(negedge clk) begin
    logic [15:0] v;
    v = env_mem.exists(mem_addr) ? env_mem[mem_addr] : init_val(mem_addr);
    mem_rdata    <= (mem_rd && scnt == L - 1) ? v : ~v;
    c1_mem_rdata <= c1_mem_rd ? (c1_mem_addr ^ 16'h7E57) : 16'hDEAD;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Invariants: exclusive strobes, exclusive grants, ack only under its own grant.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("invariants", {mem_rd & mem_wr, cpu_gnt & dma_gnt, cpu_ack & ~cpu_gnt, dma_ack & ~dma_gnt}, 0);
      chk("invariants lat1", {c1_mem_rd & c1_mem_wr, c1_cpu_gnt & c1_dma_gnt,
                              c1_cpu_ack & ~c1_cpu_gnt, c1_dma_ack & ~c1_dma_gnt}, 0);
    end
  end

  task automatic apply_reset();
    cpu_req = 0; dma_req = 0; c1_cpu_req = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // One isolated transaction, with checks on latency, strobes, bus values and rdata.
  task automatic run_txn(input bit is_dma, input bit we, input logic [15:0] addr,
                         input logic [15:0] wd, input logic [15:0] exp_rd, input string tag);
    int rdc, wrc, lat;
    bit bad_bus, other;
    logic [15:0] rd_at_ack;
    rdc = 0; wrc = 0; lat = 0; bad_bus = 0; other = 0; rd_at_ack = 16'h0;
    if (is_dma) begin dma_we = we; dma_addr = addr; dma_wdata = wd; dma_req = 1; end
    else        begin cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1; end
    for (int i = 1; i <= L + 4 && lat == 0; i++) begin
      @(negedge clk);
      if (mem_rd) rdc++;
      if (mem_wr) wrc++;
      if ((mem_rd || mem_wr) && (mem_addr != addr || (we && mem_wdata != wd))) bad_bus = 1;
      if (is_dma ? (cpu_gnt | cpu_ack) : (dma_gnt | dma_ack)) other = 1;
      if (is_dma ? dma_ack : cpu_ack) begin
        lat = i; rd_at_ack = rdata; cpu_req = 0; dma_req = 0;
      end
    end
    cpu_req = 0; dma_req = 0;
    chk({tag, " ack latency"}, lat, L + 1);
    chk({tag, " rd cycles"}, rdc, we ? 0 : L);
    chk({tag, " wr cycles"}, wrc, we ? L : 0);
    chk({tag, " bus values"}, bad_bus, 0);
    chk({tag, " other port idle"}, other, 0);
    chk({tag, " rdata"}, rd_at_ack, exp_rd);
    @(negedge clk);
    chk({tag, " release"}, {cpu_gnt, dma_gnt, cpu_ack, dma_ack, mem_rd, mem_wr}, 0);
  endtask

  typedef struct {
    bit          dma;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  logic [15:0] mdl_mem [logic [15:0]];

  initial begin
    vec_t tbl[7];
    int   exp_who[4];
    int   who[4];
    int   when[4];
    int   nack, lat, rdc;
    bit   seen;
    logic [15:0] rdat;

    tbl[0] = '{0, 0, 16'h0010, 16'h0000, 16'hBEEF};
    tbl[1] = '{1, 1, 16'h00FF, 16'h1234, 16'hBEEF};
    tbl[2] = '{0, 0, 16'h00FF, 16'h0000, 16'h1234};
    tbl[3] = '{1, 0, 16'h0010, 16'h0000, 16'hBEEF};
    tbl[4] = '{0, 1, 16'h0020, 16'h5A5A, 16'hBEEF};
    tbl[5] = '{1, 0, 16'h0020, 16'h0000, 16'h5A5A};
    tbl[6] = '{0, 0, 16'h0031, 16'h0000, 16'hA594};

    cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    c1_cpu_we = 0; c1_cpu_addr = 0; c1_cpu_wdata = 0;
    c1_dma_req = 0; c1_dma_we = 0; c1_dma_addr = 0; c1_dma_wdata = 0;
    cpu_req = 0; dma_req = 0; c1_cpu_req = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {cpu_gnt, dma_gnt, cpu_ack, dma_ack, mem_rd, mem_wr, mem_addr, mem_wdata, rdata}, 0);
    chk("reset outputs lat1", {c1_cpu_gnt, c1_dma_gnt, c1_cpu_ack, c1_dma_ack, c1_mem_rd, c1_mem_wr,
                               c1_mem_addr, c1_mem_wdata, c1_rdata}, 0);
    rst_n = 1;

    // Table of isolated transactions.
    for (int i = 0; i < 7; i++)
      run_txn(tbl[i].dma, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata,
              $sformatf("vec%0d", i));

    // Reset asserted during BUSY abandons the access without an ack.
    apply_reset();
    cpu_we = 0; cpu_addr = 16'h0010; cpu_req = 1;
    @(negedge clk);
    chk("midbusy strobe", {mem_rd, cpu_gnt}, 2'b11);
    rst_n = 0;
    #1;
    chk("midbusy async clear", {cpu_gnt, dma_gnt, cpu_ack, dma_ack, mem_rd, mem_wr, mem_addr, mem_wdata, rdata}, 0);
    cpu_req = 0;
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (L + 4) begin
      @(negedge clk);
      if (cpu_ack || cpu_gnt || dma_gnt || mem_rd) seen = 1;
    end
    chk("no ack after reset", seen, 0);
    run_txn(0, 0, 16'h0010, 16'h0000, 16'hBEEF, "post-reset read");

    // Both requesters held high: three grants, then the CPU drops its request.
    apply_reset();
`ifdef ARB_CPU_PRIORITY_EN
    exp_who = '{0, 0, 0, 1};
`else
    exp_who = '{0, 1, 0, 1};
`endif
    who = '{9, 9, 9, 9};
    when = '{0, 0, 0, 0};
    nack = 0;
    cpu_we = 0; cpu_addr = 16'h0010; dma_we = 0; dma_addr = 16'h0020;
    cpu_req = 1; dma_req = 1;
    for (int i = 1; i <= 60 && nack < 4; i++) begin
      @(negedge clk);
      if (cpu_ack || dma_ack) begin
        who[nack] = dma_ack ? 1 : 0;
        when[nack] = i;
        nack++;
        if (nack == 3) cpu_req = 0;
        if (nack == 4) dma_req = 0;
      end
    end
    cpu_req = 0; dma_req = 0;
    chk("tie ack count", nack, 4);
    chk("tie first ack latency", when[0], L + 1);
    for (int k = 0; k < 4; k++) chk($sformatf("tie grant %0d", k), who[k], exp_who[k]);
    for (int k = 1; k < 4; k++) chk($sformatf("tie spacing %0d", k), when[k] - when[k-1], L + 2);
    repeat (2) @(negedge clk);

    // MEM_LAT = 1: one strobe cycle, ack two cycles after sampling.
    c1_cpu_we = 0; c1_cpu_addr = 16'h0033; c1_cpu_req = 1;
    lat = 0; rdc = 0; rdat = 0;
    for (int i = 1; i <= 6 && lat == 0; i++) begin
      @(negedge clk);
      if (c1_mem_rd) rdc++;
      if (c1_cpu_ack) begin lat = i; rdat = c1_rdata; c1_cpu_req = 0; end
    end
    c1_cpu_req = 0;
    chk("lat1 rd cycles", rdc, 1);
    chk("lat1 ack latency", lat, 2);
    chk("lat1 rdata", rdat, 16'h7E64);

    // Randomized traffic against a transaction-level model.
    apply_reset();
    begin : rand_phase
      bit          act, a_dma, a_we, m_last, win, e_str, e_gnt, e_ack;
      int          a_edge, free_at;
      logic [15:0] a_addr, a_wd, a_exp, m_rdata;
      act = 0; a_dma = 0; a_we = 0; m_last = 1; win = 0;
      a_edge = 0; free_at = 0; a_addr = 0; a_wd = 0; a_exp = 0; m_rdata = 0;
      for (int c = 0; c < 3000; c++) begin
        e_str = act && c >= a_edge && c < a_edge + L;
        e_gnt = act && c >= a_edge && c <= a_edge + L;
        e_ack = act && c == a_edge + L;
        if (e_ack && !a_we) m_rdata = a_exp;
        chk("rand ctrl", {cpu_gnt, dma_gnt, cpu_ack, dma_ack, mem_rd, mem_wr},
            {e_gnt && !a_dma, e_gnt && a_dma, e_ack && !a_dma, e_ack && a_dma, e_str && !a_we, e_str && a_we});
        chk("rand rdata", rdata, m_rdata);
        if (e_str) chk("rand bus", {mem_addr, a_we ? mem_wdata : 16'h0}, {a_addr, a_we ? a_wd : 16'h0});
        if (e_ack) begin
          act = 0;
          if (a_dma) dma_req = 0; else cpu_req = 0;
        end
        if (!cpu_req && $urandom_range(0, 2) == 0) begin
          cpu_we = 1'($urandom_range(0, 1));
          cpu_addr = 16'h0080 + 16'($urandom_range(0, 15));
          cpu_wdata = 16'($urandom);
          cpu_req = 1;
        end
        if (!dma_req && $urandom_range(0, 2) == 0) begin
          dma_we = 1'($urandom_range(0, 1));
          dma_addr = 16'h0080 + 16'($urandom_range(0, 15));
          dma_wdata = 16'($urandom);
          dma_req = 1;
        end
        if (!act && c + 1 >= free_at && (cpu_req || dma_req)) begin
`ifdef ARB_CPU_PRIORITY_EN
          win = !cpu_req;
`else
          if (cpu_req && dma_req) win = !m_last;
          else                    win = dma_req;
`endif
          a_dma  = win;
          a_we   = win ? dma_we : cpu_we;
          a_addr = win ? dma_addr : cpu_addr;
          a_wd   = win ? dma_wdata : cpu_wdata;
          if (a_we) begin
            mdl_mem[a_addr] = a_wd;
            a_exp = 16'h0;
          end else begin
            a_exp = mdl_mem.exists(a_addr) ? mdl_mem[a_addr] : init_val(a_addr);
          end
          m_last  = win;
          a_edge  = c + 1;
          free_at = a_edge + L + 2;
          act     = 1;
        end
        @(negedge clk);
      end
      cpu_req = 0; dma_req = 0;
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port program/data memory between the CPU multicycle controller and the DMA/loader requester.
- Each requester issues a req/ack transaction. The arbiter grants one requester at a time and drives the memory strobes for a fixed access latency.
- Returns read data with a one-cycle ack pulse.
- Sits between the CPU memory interface (MAR/MDR path), the loader, and the memory macro.

Parameters:
- ADDR_W, 16, memory word-address width
- DATA_W, 16, memory data width
- MEM_LAT, 2, memory access cycles with strobe held; legal range 1..15

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU owns memory port
- cpu_ack  out  1  one-cycle completion pulse to CPU
- dma_req  in  1  DMA access request; held until dma_ack
- dma_we  in  1  DMA write enable
- dma_addr  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_gnt  out  1  DMA owns memory port
- dma_ack  out  1  one-cycle completion pulse to DMA
- rdata  out  DATA_W  read data of last completed read; valid with ack
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data; valid on the last cycle of the strobe

Behaviour:
- Reset (Reset=0, async): state=IDLE, cnt=0, last_gnt=DMA.
- Reset (outputs): cpu_gnt, dma_gnt, cpu_ack, dma_ack, mem_rd and mem_wr are 0; mem_addr, mem_wdata and rdata are 0.
- Reset mid-transaction: the transaction is abandoned and no ack is issued.
- All outputs are registered. The FSM has three states: IDLE, BUSY, RESP.
- IDLE, no request: if neither req is sampled high, stay in IDLE with all strobes 0.
- IDLE, request present: pick a winner (see arbitration), then at the same edge:
  - latch the winner's addr/wdata/we into mem_addr/mem_wdata;
  - set mem_rd = ~we, mem_wr = we;
  - set the winner's gnt = 1, cnt = MEM_LAT-1, last_gnt = winner;
  - go to BUSY.
- BUSY: strobe, address and data held constant.
  - cnt != 0: decrement cnt.
  - cnt == 0: clear mem_rd/mem_wr. For a read, rdata <= mem_rdata. Assert the winner's ack. Go to RESP.
- RESP: ack=1 and gnt=1 for exactly this cycle. Next edge: clear ack and gnt, go to IDLE.
- Latency: req sampled at edge k → strobe high for cycles k+1..k+MEM_LAT → ack high in cycle k+MEM_LAT+1.
  - Example: MEM_LAT=2 gives ack 3 cycles after req is sampled.
  - Back-to-back transactions: minimum spacing is MEM_LAT+2 cycles.
- Arbitration (default): round-robin.
  - Single request: granted.
  - Both requesting: grant the requester not equal to last_gnt. After reset the CPU wins the first tie.
- Requests arriving during BUSY/RESP wait; they are evaluated only in IDLE.
- A req still high in the IDLE cycle after ack is treated as a new transaction. Requesters drop req in the ack cycle for single accesses.
- req deasserted mid-transaction: the transaction still completes and ack still pulses.
- Invariants:
  - mem_rd & mem_wr is never 1.
  - cpu_gnt & dma_gnt is never 1.
  - ack is only asserted while the matching gnt is 1.
- Writes leave rdata unchanged. rdata holds its value until the next completed read.
- Parameter range: MEM_LAT=1 gives a single strobe cycle with cnt loaded as 0. Values outside 1..15 are illegal and an elaboration error.

Optional Feature:
- Macro: ARB_CPU_PRIORITY_EN
- Defined: fixed priority; the CPU always wins when both request, and DMA is served only when cpu_req=0 in IDLE. last_gnt is still updated but unused.
- Undefined: round-robin as above.

Test Plan:
- Reset mid-BUSY (MEM_LAT=2): CPU read to 0x0010, assert Reset=0 during BUSY → all outputs 0 immediately; no cpu_ack after release; next request runs normally.
- Single CPU read (MEM_LAT=2): cpu_req=1, cpu_addr=0x0010, memory returns 0xBEEF:
  - mem_rd high exactly 2 cycles with mem_addr=0x0010;
  - cpu_ack one cycle later with rdata=0xBEEF;
  - dma_gnt stays 0.
- DMA write: dma_we=1, dma_addr=0x00FF, dma_wdata=0x1234 → mem_wr high 2 cycles with those values; dma_ack pulses; rdata unchanged from the previous read.
- Simultaneous requests after reset, both held for 3 transactions → grant order CPU, DMA, CPU.
  - Each ack is separated by MEM_LAT+2 cycles.
  - Never two gnts high at once.
- Same stimulus with ARB_CPU_PRIORITY_EN defined → CPU granted all 3 times; DMA granted only after cpu_req drops.
- MEM_LAT=1: CPU read → mem_rd high 1 cycle, cpu_ack 2 cycles after req sampled.
